// File: rtl/l1_train_pkg.sv
// Shared types for the layer-1 ODESA training sequencer.
// Holds the update opcode, the FSM state encoding and the trace threshold default.
package l1_train_pkg;

   typedef enum logic [1:0] {
      OP_NONE   = 2'd0,
      OP_REWARD = 2'd1,
      OP_PUNISH = 2'd2,
      OP_TRACE  = 2'd3
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_DECIDE,
      ST_ISSUE1,
      ST_WAIT_LAS,
      ST_ISSUE2,
      ST_DRAIN
   } state_t;

   localparam int unsigned L1_TRACE_LL = 6;

endpackage

// File: rtl/l1_train_sequencer_rise_sticky.sv
// Edge/level detector with a sticky flag that latches the first trigger while armed.
// Ports: i_clk, i_rst_n (sync, active low), i_sig, i_arm, i_clr -> o_set (first-trigger pulse), o_sticky.
module rise_sticky #(
   parameter bit P_LEVEL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   input  logic i_arm,
   input  logic i_clr,
   output logic o_set,
   output logic o_sticky
);

   logic prev_q;
   logic sticky_q;
   logic trig;

   // Level mode triggers on any high cycle, edge mode on a 0->1 transition.
   assign trig     = P_LEVEL ? i_sig : (i_sig & ~prev_q);
   assign o_set    = i_arm & trig & ~sticky_q;
   assign o_sticky = sticky_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         prev_q   <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         prev_q <= i_sig;
         if (i_clr) begin
            sticky_q <= 1'b0;
         end else if (o_set) begin
            sticky_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/l1_train_sequencer.sv
// Layer-1 ODESA training sequencer: per event window, collects winner/GAS/LAS and issues
// reward/punish (and optionally trace) commands over a valid/ready port; counts epochs.
// Ports: i_clk, i_rst_n, i_event, i_spike, i_gas, i_las, i_tr, i_upd_ready ->
//        o_upd_valid, o_upd_op, o_upd_mask, o_las, o_busy, o_epoch, o_end_of_epochs.
// Optional feature macro: L1_TRACE_REWARD_EN enables the LAS/trace second command.
module l1_train_sequencer
   import l1_train_pkg::*;
#(
   parameter int unsigned P_NEURONS  = 2,
   parameter int unsigned P_INPUTS   = 8,
   parameter int unsigned P_TR_W     = 9,
   parameter int unsigned P_WAIT_L1  = 7,
   parameter int unsigned P_WAIT_L2  = 9,
   parameter int unsigned P_WAIT_END = 10,
   parameter int unsigned P_EPOCHS   = 20120,
   parameter int unsigned P_TRACE_LL = L1_TRACE_LL
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [P_INPUTS-1:0]           i_event,
   input  logic [P_NEURONS-1:0]          i_spike,
   input  logic                          i_gas,
   input  logic                          i_las,
   input  logic [P_NEURONS*P_TR_W-1:0]   i_tr,
   output logic                          o_upd_valid,
   input  logic                          i_upd_ready,
   output logic [1:0]                    o_upd_op,
   output logic [P_NEURONS-1:0]          o_upd_mask,
   output logic                          o_las,
   output logic                          o_busy,
   output logic [$clog2(P_EPOCHS+1)-1:0] o_epoch,
   output logic                          o_end_of_epochs
);

   localparam int unsigned CW = $clog2(P_WAIT_END + 4);
   localparam int unsigned EW = $clog2(P_EPOCHS + 1);

   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic [CW-1:0]        cnt_d;
   logic                 gas_q;
   logic [P_NEURONS-1:0] winner_q;
   logic                 valid_q;
   op_t                  op_q;
   logic [P_NEURONS-1:0] mask_q;
   logic [EW-1:0]        epoch_q;
   logic                 end_q;
   logic                 idle;
   logic                 ev_arm;
   logic                 start;
   logic                 spk_set;
   logic                 spk_stk;
   logic                 unused_ev;

   assign idle  = (state_q == ST_IDLE);
   assign ev_arm = idle & ~end_q;
   // The counter freezes while a command waits for the datapath.
   assign cnt_d = (valid_q & ~i_upd_ready) ? cnt_q : cnt_q + CW'(1);

   rise_sticky #(.P_LEVEL(1'b0)) u_ev (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_sig    (|i_event),
      .i_arm    (ev_arm),
      .i_clr    (~ev_arm),
      .o_set    (start),
      .o_sticky (unused_ev)
   );

   rise_sticky #(.P_LEVEL(1'b1)) u_spk (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_sig    (|i_spike),
      .i_arm    (~idle),
      .i_clr    (start),
      .o_set    (spk_set),
      .o_sticky (spk_stk)
   );

`ifdef L1_TRACE_REWARD_EN
   logic                        las_set;
   logic                        las_stk;
   logic [P_NEURONS*P_TR_W-1:0] tr_q;
   logic [P_NEURONS-1:0]        tr_mask;

   rise_sticky #(.P_LEVEL(1'b0)) u_las (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_sig    (i_las),
      .i_arm    (~idle),
      .i_clr    (start),
      .o_set    (las_set),
      .o_sticky (las_stk)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         tr_q <= '0;
      end else if (las_set) begin
         tr_q <= i_tr;
      end
   end

   always_comb begin
      tr_mask = '0;
      for (int n = 0; n < P_NEURONS; n++) begin
         tr_mask[n] = tr_q[n*P_TR_W +: P_TR_W] > P_TR_W'(P_TRACE_LL);
      end
   end
`else
   logic unused_las;
   assign unused_las = ^{i_las, i_tr, P_TR_W'(P_TRACE_LL)};
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         gas_q    <= 1'b0;
         winner_q <= '0;
         valid_q  <= 1'b0;
         op_q     <= OP_NONE;
         mask_q   <= '0;
         epoch_q  <= '0;
         end_q    <= 1'b0;
      end else begin
         if (!idle) begin
            cnt_q <= cnt_d;
         end
         // Lowest set bit wins on simultaneous spikes.
         if (spk_set) begin
            winner_q <= i_spike & (~i_spike + P_NEURONS'(1));
         end
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q  <= ST_COLLECT;
                  cnt_q    <= '0;
                  gas_q    <= i_gas;
                  winner_q <= '0;
               end
            end
            ST_COLLECT: begin
               if (cnt_q == CW'(P_WAIT_L1)) begin
                  state_q <= ST_DECIDE;
               end
            end
            ST_DECIDE: begin
               if (gas_q) begin
                  valid_q <= 1'b1;
                  state_q <= ST_ISSUE1;
                  if (|winner_q) begin
                     op_q   <= OP_REWARD;
                     mask_q <= winner_q;
                  end else begin
                     op_q   <= OP_PUNISH;
                     mask_q <= '1;
                  end
               end else begin
                  state_q <= ST_WAIT_LAS;
               end
            end
            ST_ISSUE1: begin
               if (i_upd_ready) begin
                  valid_q <= 1'b0;
                  op_q    <= OP_NONE;
                  mask_q  <= '0;
                  state_q <= ST_WAIT_LAS;
               end
            end
            ST_WAIT_LAS: begin
               if (cnt_q >= CW'(P_WAIT_L2)) begin
`ifdef L1_TRACE_REWARD_EN
                  if (las_stk) begin
                     valid_q <= 1'b1;
                     op_q    <= OP_TRACE;
                     mask_q  <= tr_mask;
                     state_q <= ST_ISSUE2;
                  end else begin
                     state_q <= ST_DRAIN;
                  end
`else
                  state_q <= ST_DRAIN;
`endif
               end
            end
            ST_ISSUE2: begin
               if (i_upd_ready) begin
                  valid_q <= 1'b0;
                  op_q    <= OP_NONE;
                  mask_q  <= '0;
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (cnt_q >= CW'(P_WAIT_END)) begin
                  state_q <= ST_IDLE;
                  if (epoch_q != EW'(P_EPOCHS)) begin
                     epoch_q <= epoch_q + EW'(1);
                  end
                  if (epoch_q == EW'(P_EPOCHS - 1)) begin
                     end_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_upd_valid     = valid_q;
   assign o_upd_op        = op_q;
   assign o_upd_mask      = mask_q;
   assign o_las           = spk_stk;
   assign o_busy          = ~idle;
   assign o_epoch         = epoch_q;
   assign o_end_of_epochs = end_q;

endmodule

// File: tb/tb_l1_train_sequencer.sv
// Scoreboard bench for l1_train_sequencer: stimulus pushes expected commands,
// a negedge monitor compares every presented command against the queue head.
module tb_l1_train_sequencer;

   localparam int N  = 2;
   localparam int TR = 9;
`ifdef L1_TRACE_REWARD_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    ev;
   logic [N-1:0]  spike;
   logic          gas;
   logic          las;
   logic [N*TR-1:0] tr;
   logic          upd_valid;
   logic          upd_ready;
   logic [1:0]    upd_op;
   logic [N-1:0]  upd_mask;
   logic          las_o;
   logic          busy;
   logic [1:0]    epoch;
   logic          eoe;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   l1_train_sequencer #(.P_EPOCHS(3)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_event         (ev),
      .i_spike         (spike),
      .i_gas           (gas),
      .i_las           (las),
      .i_tr            (tr),
      .o_upd_valid     (upd_valid),
      .i_upd_ready     (upd_ready),
      .o_upd_op        (upd_op),
      .o_upd_mask      (upd_mask),
      .o_las           (las_o),
      .o_busy          (busy),
      .o_epoch         (epoch),
      .o_end_of_epochs (eoe)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every presented command must match the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (upd_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL beat: unexpected op %0d mask %b", upd_op, upd_mask);
            end else begin
               chk(upd_ready ? "beat" : "hold", int'({upd_op, upd_mask}), int'(exp_q[0]));
               if (upd_ready) void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_op", int'({upd_op, upd_mask}), 0);
         end
      end
   end

   // One window: inject spike/las/extra event at given cycle, stall ready, check length.
   task automatic window(input logic g, input int spk_at, input logic [N-1:0] spk,
                         input int las_at, input logic [N*TR-1:0] trv, input int stall,
                         input int ev_at, input int exp_len, input string nm);
      int  len;
      bit  done;
      ev  = 8'h04;
      gas = g;
      tick();
      ev  = 8'h00;
      gas = 1'b0;
      len  = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (!busy) begin
            done = 1'b1;
         end else begin
            len++;
            spike     = (c == spk_at) ? spk : '0;
            las       = (las_at >= 0) && (c >= las_at);
            tr        = trv;
            ev        = (c == ev_at) ? 8'h10 : 8'h00;
            upd_ready = !(c >= 9 && c < 9 + stall);
            tick();
         end
      end
      spike     = '0;
      las       = 1'b0;
      ev        = 8'h00;
      upd_ready = 1'b1;
      chk({nm, "_len"}, len, exp_len);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      ev = '0; spike = '0; gas = 1'b0; las = 1'b0; tr = '0;
      upd_ready = 1'b1;
      tick(3);
      chk("rst_busy", busy, 0);
      chk("rst_valid", upd_valid, 0);
      chk("rst_epoch", epoch, 0);
      chk("rst_end", eoe, 0);
      chk("rst_las", las_o, 0);
      rst_n = 1'b1;
      tick(2);

      // Reward the single spiking neuron 1.
      exp_q.push_back({2'd1, 2'b10});
      window(1'b1, 3, 2'b10, -1, '0, 0, -1, 12, "t1");
      chk("t1_las", las_o, 1);
      chk("t1_epoch", epoch, 1);

      // GAS without winner punishes all; no GAS gives no beat.
      exp_q.push_back({2'd2, 2'b11});
      window(1'b1, -1, 2'b00, -1, '0, 0, -1, 12, "t2a");
      chk("t2a_las", las_o, 0);
      chk("t2a_epoch", epoch, 2);
      window(1'b0, -1, 2'b00, -1, '0, 0, -1, 11, "t2b");
      chk("t6_epoch", epoch, 3);
      chk("t6_end", eoe, 1);

      // Training frozen: further events are ignored.
      ev = 8'h01;
      tick();
      ev = 8'h00;
      chk("t6_busy_a", busy, 0);
      tick(3);
      chk("t6_busy_b", busy, 0);
      chk("t6_sat", epoch, 3);

      do_reset();
      chk("rr_epoch", epoch, 0);
      chk("rr_end", eoe, 0);

      // Simultaneous spikes: lowest index wins; 5-cycle stall holds the beat.
      exp_q.push_back({2'd1, 2'b01});
      window(1'b1, 2, 2'b11, -1, '0, 5, -1, 17, "t3");
      chk("t3_epoch", epoch, 1);

      // LAS rise at cnt 8 with traces n0=4, n1=20.
      if (EN) exp_q.push_back({2'd3, 2'b10});
      window(1'b0, -1, 2'b00, 8, {9'd20, 9'd4}, 0, -1, EN ? 12 : 11, "t4");
      chk("t4_epoch", epoch, 2);

      do_reset();
      // Reward then trace with boundary traces n0=7 (>6), n1=6 (not >6).
      exp_q.push_back({2'd1, 2'b01});
      if (EN) exp_q.push_back({2'd3, 2'b01});
      window(1'b1, 5, 2'b01, 8, {9'd6, 9'd7}, 0, -1, EN ? 13 : 12, "t4b");
      chk("t4b_epoch", epoch, 1);

      // Event mid-window is ignored.
      window(1'b0, -1, 2'b00, -1, '0, 0, 4, 11, "t5a");
      chk("t5a_epoch", epoch, 2);

      // Reset while a command is stalled in ISSUE1.
      exp_q.push_back({2'd2, 2'b11});
      upd_ready = 1'b0;
      ev  = 8'h02;
      gas = 1'b1;
      tick();
      ev  = 8'h00;
      gas = 1'b0;
      k = 0;
      while (!upd_valid && k < 20) begin
         tick();
         k++;
      end
      chk("t5b_valid", upd_valid, 1);
      tick(2);
      rst_n = 1'b0;
      tick();
      chk("t5b_busy", busy, 0);
      chk("t5b_valid0", upd_valid, 0);
      chk("t5b_epoch", epoch, 0);
      exp_q.delete();
      rst_n = 1'b1;
      upd_ready = 1'b1;
      tick(3);

      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
